// File: rtl/rto_spi_sequencer.sv
//============================================================================
// Module   : rto_spi_sequencer
// Brief    : Queues timed RTO entries and replays each payload as an SPI
//            mode-0 write to DDS/DAC peripherals, reporting dropped entries.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module rto_spi_sequencer #(
    parameter int CLK_DIV     = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int NUM_CS      = 4,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              counter_matched,
    input  logic [127:0]      rto_in,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              busy,
    output logic              overflow_error,
    output logic [127:0]      overflow_error_data
);

    localparam int              c_AW         = $clog2(QUEUE_DEPTH);
    localparam int              c_EW         = 45;
    localparam logic [c_AW:0]   c_DEPTH      = (c_AW+1)'(QUEUE_DEPTH);
    localparam logic [15:0]     c_SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0]     c_HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0]     c_DIV_LAST   = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Only the fields the shifter needs are stored: {lsb_first, cs_mask, nbits, payload}
    logic [c_EW-1:0]   r_queue [QUEUE_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;

    state_t            r_state;
    logic [15:0]       r_cnt;
    logic [31:0]       r_shreg;
    logic [5:0]        r_bits_left;

    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [c_EW-1:0]   w_head;
    logic [7:0]        w_nbits_raw;
    logic [5:0]        w_nbits;
    logic [NUM_CS-1:0] w_mask;
    logic [31:0]       w_shl;
    logic [31:0]       w_rev;
    logic [31:0]       w_aligned;

    assign w_full = (r_count == c_DEPTH);
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    assign w_push = counter_matched && (!w_full || w_pop);
    assign w_drop = counter_matched && w_full && !w_pop;

    assign w_head      = r_queue[r_rd_ptr];
    assign w_nbits_raw = w_head[39:32];
    assign w_nbits     = ((w_nbits_raw == 8'd0) || (w_nbits_raw > 8'd32)) ? 6'd32 : w_nbits_raw[5:0];
    assign w_mask      = w_head[40 +: NUM_CS];

    // Both bit orders are normalised so the next bit to send is always at bit 0.
    assign w_shl = w_head[31:0] << (6'd32 - w_nbits);
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < 32; i++) begin
            w_rev[i] = w_shl[31-i];
        end
    end
    assign w_aligned = w_head[44] ? w_head[31:0] : w_rev;

    assign busy = (r_state != S_IDLE) || (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_queue[r_wr_ptr] <= {rto_in[108:96], rto_in[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr            <= '0;
            r_rd_ptr            <= '0;
            r_count             <= '0;
            overflow_error      <= 1'b0;
            overflow_error_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            overflow_error <= w_drop;
            if (w_drop) begin
                overflow_error_data <= rto_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_bits_left <= '0;
            spi_sclk    <= 1'b0;
            spi_mosi    <= 1'b0;
            spi_cs_n    <= '1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    spi_sclk <= 1'b0;
                    spi_mosi <= 1'b0;
                    spi_cs_n <= '1;
                    r_cnt    <= '0;
                    if (w_pop && (w_mask != '0)) begin
                        r_state     <= S_SETUP;
                        spi_cs_n    <= ~w_mask;
                        spi_mosi    <= w_aligned[0];
                        r_shreg     <= w_aligned >> 1;
                        r_bits_left <= w_nbits;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == c_SETUP_LAST) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == c_DIV_LAST) begin
                        r_cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                        end else begin
                            // Falling edge: data advances here so it is stable at the next rise.
                            spi_sclk <= 1'b0;
                            if (r_bits_left == 6'd1) begin
                                r_state <= S_HOLD;
                            end else begin
                                spi_mosi    <= r_shreg[0];
                                r_shreg     <= r_shreg >> 1;
                                r_bits_left <= r_bits_left - 6'd1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_state  <= S_IDLE;
                        r_cnt    <= '0;
                        spi_cs_n <= '1;
                        spi_mosi <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rto_spi_sequencer.sv
//============================================================================
// Module   : tb_rto_spi_sequencer
// Brief    : Self-checking bench: directed vectors, corner sequences and
//            randomized traffic against a cycle-level reference model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_rto_spi_sequencer;

    localparam int CLK_DIV     = 2;
    localparam int QUEUE_DEPTH = 4;
    localparam int NUM_CS      = 4;
    localparam int CS_SETUP    = 2;
    localparam int CS_HOLD     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              counter_matched;
    logic [127:0]      rto_in;
    logic              spi_sclk;
    logic              spi_mosi;
    logic [NUM_CS-1:0] spi_cs_n;
    logic              busy;
    logic              overflow_error;
    logic [127:0]      overflow_error_data;

    rto_spi_sequencer #(
        .CLK_DIV     (CLK_DIV),
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .NUM_CS      (NUM_CS),
        .CS_SETUP    (CS_SETUP),
        .CS_HOLD     (CS_HOLD)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .counter_matched     (counter_matched),
        .rto_in              (rto_in),
        .spi_sclk            (spi_sclk),
        .spi_mosi            (spi_mosi),
        .spi_cs_n            (spi_cs_n),
        .busy                (busy),
        .overflow_error      (overflow_error),
        .overflow_error_data (overflow_error_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: queue of raw entries plus the currently active transaction window.
    logic [127:0] mq[$];
    bit           model_on = 0;
    bit           act_valid;
    int           act_start, act_n, free_at;
    logic [31:0]  act_payload;
    logic [3:0]   act_mask;
    logic         act_lsb;
    logic         m_ovf;
    logic [127:0] m_odata;

    // Sampled DUT outputs and bus monitor
    logic [3:0]   s_cs;
    logic         s_sclk, s_mosi, s_busy, s_ovf;
    logic [127:0] s_odata;
    bit           prev_low = 0, prev_sclk = 0, mon_done = 0, mon_have_end = 0;
    int           mon_len, mon_rises, mon_start, mon_txn = 0, last_end, mon_max_gap = 0;
    int           mon_ovf_count = 0, mon_ovf_cyc = 0;
    logic [31:0]  mon_seq;
    logic [3:0]   mon_cs;
    logic [127:0] mon_ovf_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] p, input logic [7:0] n,
                                        input logic [3:0] m, input logic l);
        return {19'h5A5A5, l, m, n, 32'hC0FFEE00 ^ p, 32'h7157A3E1, p};
    endfunction

    function automatic logic exp_bit(input int i);
        return act_lsb ? act_payload[i] : act_payload[act_n-1-i];
    endfunction

    task automatic model_step(input logic stb, input logic [127:0] d, input logic rs);
        bit pop, full, drop;
        logic [127:0] e;
        int n;
        if (rs) begin
            mq.delete();
            act_valid = 0;
            free_at   = cyc + 1;
            m_ovf     = 0;
            m_odata   = '0;
            model_on  = 1;
            return;
        end
        if (!model_on) return;
        pop  = (cyc >= free_at) && (mq.size() > 0);
        full = (mq.size() == QUEUE_DEPTH);
        drop = stb && full && !pop;
        if (pop) begin
            e = mq.pop_front();
            n = int'(e[103:96]);
            if (n == 0 || n > 32) n = 32;
            if (e[107:104] != 4'b0) begin
                act_valid   = 1;
                act_start   = cyc + 1;
                act_n       = n;
                act_payload = e[31:0];
                act_mask    = e[107:104];
                act_lsb     = e[108];
                free_at     = cyc + 1 + CS_SETUP + 2*CLK_DIV*n + CS_HOLD;
            end else begin
                free_at = cyc + 1;
            end
        end
        if (stb && !drop) mq.push_back(d);
        m_ovf = drop;
        if (drop) m_odata = d;
    endtask

    task automatic cycle(input logic stb, input logic [127:0] d, input logic rs);
        logic [3:0] e_cs;
        logic e_sclk, e_mosi, e_busy;
        int k, k2;
        bit cs_low;
        counter_matched = stb;
        rto_in          = d;
        reset           = rs;
        @(negedge clk);
        s_cs = spi_cs_n; s_sclk = spi_sclk; s_mosi = spi_mosi;
        s_busy = busy; s_ovf = overflow_error; s_odata = overflow_error_data;
        if (model_on) begin
            e_cs = 4'hF; e_sclk = 1'b0; e_mosi = 1'b0;
            if (act_valid && cyc >= act_start && cyc < free_at) begin
                k    = cyc - act_start;
                e_cs = ~act_mask;
                if (k < CS_SETUP) begin
                    e_mosi = exp_bit(0);
                end else begin
                    k2 = k - CS_SETUP;
                    if (k2 < 2*CLK_DIV*act_n) begin
                        e_sclk = ((k2 % (2*CLK_DIV)) >= CLK_DIV);
                        e_mosi = exp_bit(k2 / (2*CLK_DIV));
                    end else begin
                        e_mosi = exp_bit(act_n - 1);
                    end
                end
            end
            e_busy = (cyc < free_at) || (mq.size() != 0);
            chk("spi_cs_sclk_mosi_busy", {s_cs, s_sclk, s_mosi, s_busy}, {e_cs, e_sclk, e_mosi, e_busy});
            chk("overflow_error", s_ovf, m_ovf);
            chk("overflow_error_data", s_odata, m_odata);
        end
        cs_low = (s_cs != 4'hF);
        if (cs_low && !prev_low) begin
            mon_txn++;
            mon_start = cyc; mon_len = 0; mon_rises = 0; mon_seq = '0; mon_cs = s_cs; mon_done = 0;
            if (mon_have_end && (cyc - last_end) > mon_max_gap) mon_max_gap = cyc - last_end;
        end
        if (cs_low) begin
            mon_len++;
            if (s_sclk && !prev_sclk) begin
                mon_rises++;
                mon_seq = {mon_seq[30:0], s_mosi};
            end
        end
        if (!cs_low && prev_low) begin
            mon_done = 1; last_end = cyc; mon_have_end = 1;
        end
        prev_low  = cs_low;
        prev_sclk = s_sclk;
        if (s_ovf) begin
            mon_ovf_count++; mon_ovf_cyc = cyc; mon_ovf_data = s_odata;
        end
        @(posedge clk);
        model_step(stb, d, rs);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && ((cyc < free_at) || mq.size() != 0); k++) cycle(1'b0, '0, 1'b0);
        chk("drain_timeout", ((cyc < free_at) || mq.size() != 0), 1'b0);
        idle(1);
    endtask

    typedef struct {
        logic [31:0] payload;
        logic [7:0]  nbits;
        logic [3:0]  mask;
        logic        lsb;
        logic [3:0]  exp_cs;
        int          exp_len;
        logic [31:0] exp_seq;
        int          exp_rises;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t, base;
        logic [127:0] sixth;

        vecs[0] = '{32'h000000A5, 8'd8,  4'b0001, 1'b0, 4'b1110, 36,  32'h000000A5, 8};
        vecs[1] = '{32'h00000001, 8'd0,  4'b1000, 1'b1, 4'b0111, 132, 32'h80000000, 32};
        vecs[2] = '{32'h0000003C, 8'd6,  4'b0010, 1'b0, 4'b1101, 28,  32'h0000003C, 6};
        vecs[3] = '{32'h12345678, 8'd40, 4'b0110, 1'b0, 4'b1001, 132, 32'h12345678, 32};
        vecs[4] = '{32'h0000000B, 8'd4,  4'b0100, 1'b1, 4'b1011, 20,  32'h0000000D, 4};
        vecs[5] = '{32'hFFFFFFFE, 8'd1,  4'b1111, 1'b0, 4'b0000, 8,   32'h00000000, 1};

        reset = 1'b1; counter_matched = 1'b0; rto_in = '0;
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        chk("reset_cs_n", s_cs, 4'hF);
        chk("reset_sclk_mosi_busy_ovf", {s_sclk, s_mosi, s_busy, s_ovf}, 4'b0);
        chk("reset_ovf_data", s_odata, '0);

        for (int i = 0; i < 6; i++) begin
            mon_done = 0;
            t = cyc;
            cycle(1'b1, mk(vecs[i].payload, vecs[i].nbits, vecs[i].mask, vecs[i].lsb), 1'b0);
            for (int k = 0; k < 400 && !mon_done; k++) cycle(1'b0, '0, 1'b0);
            chk($sformatf("v%0d_done", i), mon_done, 1'b1);
            chk($sformatf("v%0d_cs_start", i), mon_start, t + 2);
            chk($sformatf("v%0d_cs_n", i), mon_cs, vecs[i].exp_cs);
            chk($sformatf("v%0d_cs_len", i), mon_len, vecs[i].exp_len);
            chk($sformatf("v%0d_bits", i), mon_seq, vecs[i].exp_seq);
            chk($sformatf("v%0d_rises", i), mon_rises, vecs[i].exp_rises);
            chk($sformatf("v%0d_idle_after", i), {s_cs, s_busy}, {4'hF, 1'b0});
        end

        // Burst of six strobes overflows the four-deep queue on the last one
        drain();
        mon_ovf_count = 0; mon_max_gap = 0; mon_have_end = 0; base = mon_txn;
        t = cyc;
        for (int i = 0; i < 6; i++) begin
            sixth = mk(32'h1 + 32'(i) * 32'h3, 8'd4, 4'b0001, 1'b0);
            cycle(1'b1, sixth, 1'b0);
        end
        drain();
        chk("burst_ovf_count", mon_ovf_count, 1);
        chk("burst_ovf_cycle", mon_ovf_cyc, t + 6);
        chk("burst_ovf_data", mon_ovf_data, sixth);
        chk("burst_txn_count", mon_txn - base, 5);
        chk("burst_max_gap", mon_max_gap, 1);

        // Masked entry followed by a valid one
        mon_ovf_count = 0; base = mon_txn;
        t = cyc;
        cycle(1'b1, mk(32'hFF, 8'd8, 4'b0000, 1'b0), 1'b0);
        cycle(1'b1, mk(32'h3, 8'd2, 4'b0010, 1'b0), 1'b0);
        drain();
        chk("masked_start", mon_start, t + 3);
        chk("masked_txn_count", mon_txn - base, 1);
        chk("masked_no_ovf", mon_ovf_count, 0);

        // Push on the same edge as the IDLE pop while the queue is full
        mon_ovf_count = 0; base = mon_txn;
        t = cyc;
        cycle(1'b1, mk(32'h1, 8'd1, 4'b0001, 1'b0), 1'b0);
        idle(1);
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(32'hA0 + 32'(i), 8'd3, 4'b0010, 1'b1), 1'b0);
        idle(t + 10 - cyc);
        cycle(1'b1, mk(32'h5, 8'd3, 4'b0100, 1'b0), 1'b0);
        drain();
        chk("pushpop_no_ovf", mon_ovf_count, 0);
        chk("pushpop_txn_count", mon_txn - base, 6);

        // Reset during bit 3 with two entries still queued
        t = cyc;
        cycle(1'b1, mk(32'hC3, 8'd8, 4'b0011, 1'b0), 1'b0);
        idle(1);
        cycle(1'b1, mk(32'h11, 8'd8, 4'b0001, 1'b0), 1'b0);
        cycle(1'b1, mk(32'h22, 8'd8, 4'b0001, 1'b0), 1'b0);
        idle(t + 17 - cyc);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        chk("rst_mid_cs_n", s_cs, 4'hF);
        chk("rst_mid_sclk_mosi_busy", {s_sclk, s_mosi, s_busy}, 3'b000);
        base = mon_txn;
        idle(100);
        chk("rst_mid_no_activity", mon_txn - base, 0);

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            cycle(1'($urandom_range(0, 4) == 0),
                  mk($urandom, 8'($urandom_range(0, 40)), 4'($urandom), 1'($urandom)),
                  1'($urandom_range(0, 699) == 0));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
